// File: rtl/qft_sign_pkg.sv
// qft_sign_pkg: sign-magnitude word type, constants, helpers and divider FSM states
package qft_sign_pkg;
  localparam int SM_W = 32;
  localparam int SM_FRAC = 30;
  localparam int SM_SIGN_BIT = SM_W - 1;
  typedef logic [SM_W-1:0] sm_word_t;
  localparam logic [SM_W-2:0] SM_MAG_MAX = '1;
  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} cdiv_state_t;
  function automatic sm_word_t sm_conj(input sm_word_t w);
    return {~w[SM_SIGN_BIT], w[SM_SIGN_BIT-1:0]};
  endfunction
  function automatic sm_word_t sm_norm_zero(input sm_word_t w);
    return (w[SM_SIGN_BIT-1:0] == '0) ? '0 : w;
  endfunction
endpackage

// File: rtl/sm_mag_divider.sv
// sm_mag_divider: unsigned restoring divider, (num << (QW-SH)) / den, one quotient bit per step
// ports: clk, rst, start_i (load num/den), step_i (one bit), num_i, den_i, quo_o
module sm_mag_divider #(
  parameter int NW = 63,
  parameter int QW = 31,
  parameter int SH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          step_i,
  input  logic [NW-1:0] num_i,
  input  logic [NW-1:0] den_i,
  output logic [QW-1:0] quo_o
);
  logic [NW-1:0] rem_q, rem_d, den_q, den_d;
  logic [QW-1:0] quo_q, quo_d, bits_q, bits_d;
  logic [NW:0] trial;
  logic fits;
  // remainder starts as the dividend bits above the quotient window; bits_q feeds the rest in
  assign trial = {rem_q, bits_q[QW-1]};
  assign fits = trial >= {1'b0, den_q};
  assign quo_o = quo_q;
  always_comb begin
    rem_d = rem_q;
    den_d = den_q;
    quo_d = quo_q;
    bits_d = bits_q;
    if (start_i) begin
      {rem_d, bits_d} = {num_i, {QW{1'b0}}} >> SH;
      den_d = den_i;
      quo_d = '0;
    end else if (step_i) begin
      rem_d = fits ? NW'(trial - {1'b0, den_q}) : trial[NW-1:0];
      quo_d = {quo_q[QW-2:0], fits};
      bits_d = bits_q << 1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      bits_q <= '0;
    end else begin
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
      bits_q <= bits_d;
    end
endmodule

// File: rtl/cdivider_sign.sv
// cdivider_sign: sequential sign-magnitude complex divider Q = A / B
// ports: clk, rst, in_valid/in_ready + A_real/A_img/B_real/B_img in, out_valid/out_ready + Q_real/Q_img/overflow out
// option: CDIV_ROUND_EN adds a guard-bit step and rounds half-up, otherwise truncates
module cdivider_sign
  import qft_sign_pkg::*;
#(
  parameter int DATA_W = SM_W,
  parameter int FRAC_W = SM_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A_real,
  input  logic [DATA_W-1:0] A_img,
  input  logic [DATA_W-1:0] B_real,
  input  logic [DATA_W-1:0] B_img,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Q_real,
  output logic [DATA_W-1:0] Q_img,
  output logic              overflow
);
  localparam int MW = DATA_W - 1;
  localparam int PW = 2 * MW + 1;
  localparam int SH = MW - FRAC_W;
`ifdef CDIV_ROUND_EN
  localparam int STEPS = MW + 1;
`else
  localparam int STEPS = MW;
`endif
  localparam int CW = $clog2(STEPS);
  function automatic logic [PW-1:0] mag_mul(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return PW'(x[MW-1:0]) * PW'(y[MW-1:0]);
  endfunction
  function automatic logic [PW:0] sm_add(input logic sa, input logic [PW-1:0] ma, input logic sb, input logic [PW-1:0] mb);
    if (sa == sb) return {sa, PW'(ma + mb)};
    return (ma >= mb) ? {sa, PW'(ma - mb)} : {sb, PW'(mb - ma)};
  endfunction
  cdiv_state_t state_q, state_d;
  logic [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d, b_re_q, b_re_d, b_im_q, b_im_d, b_cj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, sat_re_q, sat_re_d, sat_im_q, sat_im_d, sgn_re_q, sgn_re_d, sgn_im_q, sgn_im_d;
  logic [PW:0] n_re, n_im;
  logic [PW-1:0] d_mag;
  logic d_zero, sat_re, sat_im, start, step;
  logic [STEPS-1:0] quo_re, quo_im;
  logic [MW-1:0] mag_re, mag_im;
  logic cy_re, cy_im;
  // full-precision N = A*conj(B) and D = |B|^2, both scaled by 2^(2*FRAC_W)
  assign b_cj = sm_conj(b_im_q);
  assign n_re = sm_add(a_re_q[MW] ^ b_re_q[MW], mag_mul(a_re_q, b_re_q),
                       a_im_q[MW] ^ b_im_q[MW], mag_mul(a_im_q, b_im_q));
  assign n_im = sm_add(a_im_q[MW] ^ b_re_q[MW], mag_mul(a_im_q, b_re_q),
                       a_re_q[MW] ^ b_cj[MW], mag_mul(a_re_q, b_cj));
  assign d_mag = mag_mul(b_re_q, b_re_q) + mag_mul(b_im_q, b_im_q);
  assign d_zero = d_mag == '0;
  // quotient would not fit the magnitude field
  assign sat_re = !d_zero && ({1'b0, n_re[PW-1:0]} >= ((PW+1)'(d_mag) << SH));
  assign sat_im = !d_zero && ({1'b0, n_im[PW-1:0]} >= ((PW+1)'(d_mag) << SH));
  sm_mag_divider #(.NW(PW), .QW(STEPS), .SH(SH)) u_div_re (
    .clk(clk), .rst(rst), .start_i(start), .step_i(step),
    .num_i(n_re[PW-1:0]), .den_i(d_mag), .quo_o(quo_re)
  );
  sm_mag_divider #(.NW(PW), .QW(STEPS), .SH(SH)) u_div_im (
    .clk(clk), .rst(rst), .start_i(start), .step_i(step),
    .num_i(n_im[PW-1:0]), .den_i(d_mag), .quo_o(quo_im)
  );
`ifdef CDIV_ROUND_EN
  assign {cy_re, mag_re} = {1'b0, quo_re[STEPS-1:1]} + (MW+1)'(quo_re[0]);
  assign {cy_im, mag_im} = {1'b0, quo_im[STEPS-1:1]} + (MW+1)'(quo_im[0]);
`else
  assign {cy_re, mag_re} = {1'b0, quo_re};
  assign {cy_im, mag_im} = {1'b0, quo_im};
`endif
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign Q_real = sm_norm_zero({sgn_re_q, (sat_re_q || cy_re) ? SM_MAG_MAX : mag_re});
  assign Q_img = sm_norm_zero({sgn_im_q, (sat_im_q || cy_im) ? SM_MAG_MAX : mag_im});
  assign overflow = (state_q == DONE) && (ovf_q || cy_re || cy_im);
  always_comb begin
    state_d = state_q;
    a_re_d = a_re_q;
    a_im_d = a_im_q;
    b_re_d = b_re_q;
    b_im_d = b_im_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    sat_re_d = sat_re_q;
    sat_im_d = sat_im_q;
    sgn_re_d = sgn_re_q;
    sgn_im_d = sgn_im_q;
    start = 1'b0;
    step = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        a_re_d = A_real;
        a_im_d = A_img;
        b_re_d = B_real;
        b_im_d = B_img;
        state_d = PREP;
      end
      PREP: begin
        start = 1'b1;
        cnt_d = '0;
        sgn_re_d = n_re[PW];
        sgn_im_d = n_im[PW];
        sat_re_d = sat_re;
        sat_im_d = sat_im;
        ovf_d = d_zero || sat_re || sat_im;
        state_d = d_zero ? DONE : DIV;
      end
      DIV: begin
        step = 1'b1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(STEPS - 1)) ? DONE : DIV;
      end
      DONE: if (out_ready) begin
        ovf_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      a_re_q <= '0;
      a_im_q <= '0;
      b_re_q <= '0;
      b_im_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      sat_re_q <= 1'b0;
      sat_im_q <= 1'b0;
      sgn_re_q <= 1'b0;
      sgn_im_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_re_q <= a_re_d;
      a_im_q <= a_im_d;
      b_re_q <= b_re_d;
      b_im_q <= b_im_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      sat_re_q <= sat_re_d;
      sat_im_q <= sat_im_d;
      sgn_re_q <= sgn_re_d;
      sgn_im_q <= sgn_im_d;
    end
endmodule

// File: tb/tb_cdivider_sign.sv
// tb_cdivider_sign: directed scoreboard bench for cdivider_sign
module tb_cdivider_sign;
  localparam int W = 32;
`ifdef CDIV_ROUND_EN
  localparam int LAT = W + 2;
  localparam logic [W-1:0] TWO_THIRDS = 32'h2AAAAAAB;
`else
  localparam int LAT = W + 1;
  localparam logic [W-1:0] TWO_THIRDS = 32'h2AAAAAAA;
`endif
  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic ovf;
    logic [7:0] lat;
  } exp_t;
  exp_t sb[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic in_ready, out_valid, overflow;
  logic [W-1:0] q_re, q_im;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cdivider_sign dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_real(ar), .A_img(ai), .B_real(br), .B_img(bi),
    .out_valid(out_valid), .out_ready(out_ready),
    .Q_real(q_re), .Q_img(q_im), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [W-1:0] a_re, input logic [W-1:0] a_im, input logic [W-1:0] b_re,
                       input logic [W-1:0] b_im, input logic push, input exp_t e);
    for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge clk);
    ar = a_re;
    ai = a_im;
    br = b_re;
    bi = b_im;
    in_valid = 1'b1;
    @(posedge clk);
    if (push) sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, W'(lat), W'(e.lat));
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      ar = $urandom;
      bi = $urandom;
      chk({tag, " hold out_valid"}, W'(out_valid), W'(1));
      chk({tag, " hold in_ready"}, W'(in_ready), W'(0));
      chk({tag, " hold Q_real"}, q_re, e.re);
      chk({tag, " hold Q_img"}, q_im, e.im);
      chk({tag, " hold overflow"}, W'(overflow), W'(e.ovf));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, " Q_real"}, q_re, e.re);
    chk({tag, " Q_img"}, q_im, e.im);
    chk({tag, " overflow"}, W'(overflow), W'(e.ovf));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " post out_valid"}, W'(out_valid), W'(0));
    chk({tag, " post in_ready"}, W'(in_ready), W'(1));
    chk({tag, " post overflow"}, W'(overflow), W'(0));
  endtask
  task automatic run(input string tag, input logic [W-1:0] a_re, input logic [W-1:0] a_im,
                     input logic [W-1:0] b_re, input logic [W-1:0] b_im, input logic [W-1:0] e_re,
                     input logic [W-1:0] e_im, input logic e_ovf, input int e_lat, input int hold);
    exp_t e;
    e = '{e_re, e_im, e_ovf, 8'(e_lat)};
    issue(a_re, a_im, b_re, b_im, 1'b1, e);
    collect(tag, hold);
  endtask
  initial begin
    exp_t none;
    none = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", W'(in_ready), W'(1));
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset Q_real", q_re, 32'h0);
    chk("reset Q_img", q_im, 32'h0);
    chk("reset overflow", W'(overflow), W'(0));
    run("one", 32'h40000000, 32'h0, 32'h40000000, 32'h0, 32'h40000000, 32'h0, 1'b0, LAT, 0);
    run("conj", 32'h20000000, 32'h20000000, 32'h20000000, 32'hA0000000, 32'h0, 32'h40000000, 1'b0, LAT, 0);
    run("zero div", 32'h40000000, 32'h40000000, 32'h0, 32'h80000000, 32'h0, 32'h0, 1'b1, 2, 0);
    run("range", 32'h40000000, 32'hC0000000, 32'h10000000, 32'h0, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, LAT, 0);
    run("sat edge", 32'h40000000, 32'h0, 32'h20000000, 32'h0, 32'h7FFFFFFF, 32'h0, 1'b1, LAT, 0);
    run("below sat", 32'h3FFFFFFF, 32'h0, 32'h20000000, 32'h0, 32'h7FFFFFFE, 32'h0, 1'b0, LAT, 0);
    run("two thirds", 32'h40000000, 32'h0, 32'h60000000, 32'h0, TWO_THIRDS, 32'h0, 1'b0, LAT, 0);
    run("inv i", 32'h40000000, 32'h0, 32'h0, 32'h40000000, 32'h0, 32'hC0000000, 1'b0, LAT, 0);
    run("neg div", 32'h20000000, 32'h20000000, 32'hC0000000, 32'h0, 32'hA0000000, 32'hA0000000, 1'b0, LAT, 0);
    run("hold", 32'h40000000, 32'h0, 32'h40000000, 32'h0, 32'h40000000, 32'h0, 1'b0, LAT, 5);
    issue(32'h40000000, 32'h0, 32'h40000000, 32'h0, 1'b0, none);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", W'(in_ready), W'(1));
    chk("abort out_valid", W'(out_valid), W'(0));
    chk("abort Q_real", q_re, 32'h0);
    chk("abort Q_img", q_im, 32'h0);
    chk("abort overflow", W'(overflow), W'(0));
    run("fresh", 32'h20000000, 32'h0, 32'h40000000, 32'h0, 32'h20000000, 32'h0, 1'b0, LAT, 0);
    chk("scoreboard empty", W'(sb.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
